// File: rtl/lowx_arbiter_pkg.sv
// ============================================================================
// Module   : tcore_param (package)
// Purpose  : Shared types and constants for the lower-level memory arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package tcore_param;

  localparam int LOWX_XLEN     = 32;
  localparam int LOWX_BLK_SIZE = 128;
  localparam int LOWX_TIMEOUT  = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } lowx_arb_state_e;

  typedef enum logic {
    GNT_IC = 1'b0,
    GNT_DC = 1'b1
  } lowx_gnt_e;

  typedef struct packed {
    logic [LOWX_XLEN-1:0]     addr;
    logic                     we;
    logic [LOWX_BLK_SIZE-1:0] wdata;
  } lowx_arb_req_t;

endpackage

`default_nettype wire

// File: rtl/lowx_arbiter_rr_arb2.sv
// ============================================================================
// Module   : rr_arb2
// Purpose  : Combinational two-way round-robin pick (bit 0 = IC, bit 1 = DC).
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arb2
  import tcore_param::*;
(
  input  logic [1:0] valid,
  input  logic [1:0] mask,
  input  lowx_gnt_e  last_grant,
  output logic       grant_valid,
  output lowx_gnt_e  grant
);

  logic [1:0] eligible;

  always_comb begin
    eligible    = valid & ~mask;
    grant_valid = |eligible;
    grant       = GNT_IC;
    case (eligible)
      2'b01:   grant = GNT_IC;
      2'b10:   grant = GNT_DC;
      2'b11:   grant = (last_grant == GNT_IC) ? GNT_DC : GNT_IC;
      default: grant = GNT_IC;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lowx_arbiter.sv
// ============================================================================
// Module   : lowx_arbiter
// Purpose  : Shares one memory port between I-cache and D-cache miss paths.
//            Optional watchdog enabled by macro LOWX_ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lowx_arbiter
  import tcore_param::*;
#(
  parameter int BLK_SIZE       = LOWX_BLK_SIZE,
  parameter int XLEN           = LOWX_XLEN,
  parameter int TIMEOUT_CYCLES = LOWX_TIMEOUT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                ic_req_valid_i,
  input  logic [XLEN-1:0]     ic_req_addr_i,
  output logic                ic_rsp_valid_o,
  output logic [BLK_SIZE-1:0] ic_rsp_data_o,
  input  logic                dc_req_valid_i,
  input  logic [XLEN-1:0]     dc_req_addr_i,
  input  logic                dc_req_we_i,
  input  logic [BLK_SIZE-1:0] dc_req_wdata_i,
  output logic                dc_rsp_valid_o,
  output logic [BLK_SIZE-1:0] dc_rsp_data_o,
  output logic                rsp_err_o,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [XLEN-1:0]     mem_req_addr_o,
  output logic                mem_req_we_o,
  output logic [BLK_SIZE-1:0] mem_req_wdata_o,
  input  logic                mem_rsp_valid_i,
  input  logic [BLK_SIZE-1:0] mem_rsp_data_i
);

  typedef struct packed {
    logic [XLEN-1:0]     addr;
    logic                we;
    logic [BLK_SIZE-1:0] wdata;
  } req_t;

  lowx_arb_state_e     state, state_nxt;
  lowx_gnt_e           gnt, last_grant, pick;
  logic                pick_valid;
  logic [1:0]          mask;
  req_t                req;
  logic [BLK_SIZE-1:0] rsp_data;
  logic                advance;
  logic                cnt_hit;
  logic                timeout;

  rr_arb2 u_rr_arb2 (
    .valid       ({dc_req_valid_i, ic_req_valid_i}),
    .mask        (mask),
    .last_grant  (last_grant),
    .grant_valid (pick_valid),
    .grant       (pick)
  );

  assign advance = ((state == ISSUE) && mem_req_ready_i) ||
                   ((state == WAIT)  && mem_rsp_valid_i);
  // A handshake in the same cycle as the watchdog expiry wins.
  assign timeout = cnt_hit && !advance;

`ifdef LOWX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] to_cnt;
  logic             err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if ((state == ISSUE) || (state == WAIT)) to_cnt <= to_cnt + 1'b1;
      else                                     to_cnt <= '0;
      if (state == IDLE)  err <= 1'b0;
      else if (timeout)   err <= 1'b1;
    end
  end

  assign cnt_hit   = ((state == ISSUE) || (state == WAIT)) &&
                     (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rsp_err_o = (state == RESP) && err;
`else
  assign cnt_hit   = 1'b0;
  assign rsp_err_o = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = ISSUE;
      ISSUE:   if (mem_req_ready_i) state_nxt = WAIT;
               else if (timeout)    state_nxt = RESP;
      WAIT:    if (mem_rsp_valid_i || timeout) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      gnt        <= GNT_IC;
      last_grant <= GNT_DC;
      mask       <= '0;
      req        <= '0;
      rsp_data   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          mask <= '0;
          if (pick_valid) begin
            gnt        <= pick;
            last_grant <= pick;
            if (pick == GNT_IC) req <= '{addr: ic_req_addr_i, we: 1'b0, wdata: '0};
            else                req <= '{addr: dc_req_addr_i, we: dc_req_we_i,
                                         wdata: dc_req_wdata_i};
          end
        end
        ISSUE, WAIT: begin
          if ((state == WAIT) && mem_rsp_valid_i)
            rsp_data <= req.we ? '0 : mem_rsp_data_i;
          else if (timeout)
            rsp_data <= '0;
        end
        RESP: mask <= (gnt == GNT_IC) ? 2'b01 : 2'b10;
        default: mask <= '0;
      endcase
    end
  end

  assign mem_req_valid_o = (state == ISSUE);
  assign mem_req_addr_o  = req.addr;
  assign mem_req_we_o    = req.we;
  assign mem_req_wdata_o = req.wdata;
  assign ic_rsp_valid_o  = (state == RESP) && (gnt == GNT_IC);
  assign dc_rsp_valid_o  = (state == RESP) && (gnt == GNT_DC);
  assign ic_rsp_data_o   = ic_rsp_valid_o ? rsp_data : '0;
  assign dc_rsp_data_o   = dc_rsp_valid_o ? rsp_data : '0;

endmodule

`default_nettype wire

// File: tb/tb_lowx_arbiter.sv
// ============================================================================
// Module   : tb_lowx_arbiter
// Purpose  : Directed self-checking bench for lowx_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lowx_arbiter;

`ifdef LOWX_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         ic_req_valid;
  logic [31:0]  ic_req_addr;
  logic         ic_rsp_valid;
  logic [127:0] ic_rsp_data;
  logic         dc_req_valid;
  logic [31:0]  dc_req_addr;
  logic         dc_req_we;
  logic [127:0] dc_req_wdata;
  logic         dc_rsp_valid;
  logic [127:0] dc_rsp_data;
  logic         rsp_err;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [31:0]  mem_req_addr;
  logic         mem_req_we;
  logic [127:0] mem_req_wdata;
  logic         mem_rsp_valid;
  logic [127:0] mem_rsp_data;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lowx_arbiter #(.BLK_SIZE(128), .XLEN(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .ic_req_valid_i  (ic_req_valid),
    .ic_req_addr_i   (ic_req_addr),
    .ic_rsp_valid_o  (ic_rsp_valid),
    .ic_rsp_data_o   (ic_rsp_data),
    .dc_req_valid_i  (dc_req_valid),
    .dc_req_addr_i   (dc_req_addr),
    .dc_req_we_i     (dc_req_we),
    .dc_req_wdata_i  (dc_req_wdata),
    .dc_rsp_valid_o  (dc_rsp_valid),
    .dc_rsp_data_o   (dc_rsp_data),
    .rsp_err_o       (rsp_err),
    .mem_req_valid_o (mem_req_valid),
    .mem_req_ready_i (mem_req_ready),
    .mem_req_addr_o  (mem_req_addr),
    .mem_req_we_o    (mem_req_we),
    .mem_req_wdata_o (mem_req_wdata),
    .mem_rsp_valid_i (mem_rsp_valid),
    .mem_rsp_data_i  (mem_rsp_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ic_req_valid = 0; ic_req_addr = 0;
    dc_req_valid = 0; dc_req_addr = 0; dc_req_we = 0; dc_req_wdata = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
  endtask

  // Memory model: accept in the first ISSUE cycle, answer in the first WAIT cycle.
  task automatic mem_serve(input logic [127:0] data, output logic [31:0] addr,
                           output logic got_req, output logic saw_ic, output logic saw_dc);
    got_req = 0; saw_ic = 0; saw_dc = 0; addr = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req_valid) begin
        got_req = 1;
        break;
      end
      tick();
    end
    if (got_req) begin
      addr = mem_req_addr;
      mem_req_ready = 1; tick(); mem_req_ready = 0;
      mem_rsp_valid = 1; mem_rsp_data = data; tick(); mem_rsp_valid = 0;
      saw_ic = ic_rsp_valid;
      saw_dc = dc_rsp_valid;
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    tick(); tick();
    n_cmp++;
    if ({ic_rsp_valid, dc_rsp_valid, rsp_err, mem_req_valid, mem_req_we} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {ic_rsp_valid, dc_rsp_valid, rsp_err, mem_req_valid, mem_req_we});
    end
    n_cmp++;
    if ({ic_rsp_data, dc_rsp_data, mem_req_wdata, mem_req_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got addr=%h wdata=%h want 0", mem_req_addr, mem_req_wdata);
    end
    rst = 0;
    tick();
    n_cmp++;
    if (mem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: mem_req_valid=%b want 0", mem_req_valid);
    end
  endtask

  task automatic test_ic_only();
    logic [127:0] exp;
    exp = {4{32'hDEADBEEF}};
    ic_req_valid = 1; ic_req_addr = 32'h0000_1040;
    tick();
    n_cmp++;
    if ({mem_req_valid, mem_req_addr, mem_req_we} !== {1'b1, 32'h0000_1040, 1'b0}) begin
      n_fail++;
      $display("FAIL ic_issue: valid=%b addr=%h we=%b want 1/00001040/0",
               mem_req_valid, mem_req_addr, mem_req_we);
    end
    mem_req_ready = 1; tick(); mem_req_ready = 0;
    n_cmp++;
    if ({mem_req_valid, ic_rsp_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL ic_wait: valid=%b ic_rsp=%b want 0/0", mem_req_valid, ic_rsp_valid);
    end
    tick();
    mem_rsp_valid = 1; mem_rsp_data = exp;
    tick();
    mem_rsp_valid = 0;
    n_cmp++;
    if ({ic_rsp_valid, ic_rsp_data, rsp_err} !== {1'b1, exp, 1'b0}) begin
      n_fail++;
      $display("FAIL ic_rsp: valid=%b data=%h err=%b want 1/%h/0",
               ic_rsp_valid, ic_rsp_data, rsp_err, exp);
    end
    n_cmp++;
    if ({dc_rsp_valid, dc_rsp_data} !== '0) begin
      n_fail++;
      $display("FAIL ic_dc_quiet: dc_valid=%b dc_data=%h want 0", dc_rsp_valid, dc_rsp_data);
    end
    ic_req_valid = 0;
    tick();
    n_cmp++;
    if (ic_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ic_pulse: ic_rsp_valid=%b want 0", ic_rsp_valid);
    end
  endtask

  task automatic test_no_dup();
    logic [31:0] a;
    logic g, si, sd;
    ic_req_valid = 1; ic_req_addr = 32'h0000_3000;
    mem_serve({4{32'h0BADF00D}}, a, g, si, sd);
    n_cmp++;
    if ({g, si, sd} !== 3'b110) begin
      n_fail++;
      $display("FAIL nodup_first: got req/ic/dc=%b want 110", {g, si, sd});
    end
    tick();
    tick();
    ic_req_valid = 0;
    n_cmp++;
    if (mem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL nodup_regrant: mem_req_valid=%b want 0", mem_req_valid);
    end
    tick();
    n_cmp++;
    if (mem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL nodup_later: mem_req_valid=%b want 0", mem_req_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_addr [4];
    logic [1:0]  exp_who  [4];
    logic [31:0] a;
    logic g, si, sd;
    exp_addr = '{32'h0000_1100, 32'h0000_2200, 32'h0000_1100, 32'h0000_2200};
    exp_who  = '{2'b10, 2'b01, 2'b10, 2'b01};
    rst = 1; tick(); rst = 0;
    ic_req_valid = 1; ic_req_addr = 32'h0000_1100;
    dc_req_valid = 1; dc_req_addr = 32'h0000_2200; dc_req_we = 0;
    for (int t = 0; t < 4; t++) begin
      mem_serve({4{32'h00C0FFEE}}, a, g, si, sd);
      n_cmp++;
      if (a !== exp_addr[t] || g !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_addr[%0d]: addr=%h req=%b want %h/1", t, a, g, exp_addr[t]);
      end
      n_cmp++;
      if ({si, sd} !== exp_who[t]) begin
        n_fail++;
        $display("FAIL b2b_who[%0d]: ic/dc=%b want %b", t, {si, sd}, exp_who[t]);
      end
    end
    ic_req_valid = 0; dc_req_valid = 0;
    tick(); tick();
  endtask

  task automatic test_writeback();
    logic [127:0] wd;
    wd = {16{8'hA5}};
    dc_req_valid = 1; dc_req_addr = 32'h2000_0080; dc_req_we = 1; dc_req_wdata = wd;
    tick();
    for (int s = 0; s < 5; s++) begin
      n_cmp++;
      if ({mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata} !==
          {1'b1, 32'h2000_0080, 1'b1, wd}) begin
        n_fail++;
        $display("FAIL wb_stall[%0d]: valid=%b addr=%h we=%b wdata=%h want 1/20000080/1/%h",
                 s, mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, wd);
      end
      tick();
    end
    mem_req_ready = 1; tick(); mem_req_ready = 0;
    mem_rsp_valid = 1; mem_rsp_data = {4{32'h12345678}};
    tick();
    mem_rsp_valid = 0;
    n_cmp++;
    if ({dc_rsp_valid, dc_rsp_data, ic_rsp_valid} !== {1'b1, 128'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL wb_rsp: dc_valid=%b dc_data=%h ic_valid=%b want 1/0/0",
               dc_rsp_valid, dc_rsp_data, ic_rsp_valid);
    end
    dc_req_valid = 0; dc_req_we = 0;
    tick(); tick();
  endtask

  task automatic test_rsp_ignored();
    ic_req_valid = 1; ic_req_addr = 32'h0000_4000;
    tick();
    mem_req_ready = 1; mem_rsp_valid = 1; mem_rsp_data = {4{32'h11111111}};
    tick();
    mem_req_ready = 0; mem_rsp_valid = 0;
    tick();
    n_cmp++;
    if (ic_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL early_rsp: ic_rsp_valid=%b want 0", ic_rsp_valid);
    end
    mem_rsp_valid = 1; mem_rsp_data = {4{32'h22222222}};
    tick();
    mem_rsp_valid = 0;
    n_cmp++;
    if ({ic_rsp_valid, ic_rsp_data} !== {1'b1, {4{32'h22222222}}}) begin
      n_fail++;
      $display("FAIL late_rsp: valid=%b data=%h want 1/%h",
               ic_rsp_valid, ic_rsp_data, {4{32'h22222222}});
    end
    ic_req_valid = 0;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    ic_req_valid = 1; ic_req_addr = 32'h0000_5000;
    tick();
    mem_req_ready = 1; tick(); mem_req_ready = 0;
    rst = 1;
    tick();
    n_cmp++;
    if ({ic_rsp_valid, dc_rsp_valid, rsp_err, mem_req_valid, mem_req_we, mem_req_addr} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: ic=%b dc=%b err=%b mv=%b addr=%h want all 0",
               ic_rsp_valid, dc_rsp_valid, rsp_err, mem_req_valid, mem_req_addr);
    end
    ic_req_valid = 0; rst = 0;
    mem_rsp_valid = 1; mem_rsp_data = {4{32'hFFFFFFFF}};
    tick();
    mem_rsp_valid = 0;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({ic_rsp_valid, dc_rsp_valid, mem_req_valid} !== 3'b000) begin
        n_fail++;
        $display("FAIL rst_ghost[%0d]: ic/dc/mv=%b want 000", k,
                 {ic_rsp_valid, dc_rsp_valid, mem_req_valid});
      end
      tick();
    end
  endtask

`ifdef LOWX_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    ic_req_valid = 1; ic_req_addr = 32'h0000_6000;
    tick();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (ic_rsp_valid) break;
      tick();
      n++;
    end
    n_cmp++;
    if (n !== 16) begin
      n_fail++;
      $display("FAIL to_latency: got %0d cycles want 16", n);
    end
    n_cmp++;
    if ({ic_rsp_valid, rsp_err, ic_rsp_data, mem_req_valid} !== {1'b1, 1'b1, 128'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL to_rsp: valid=%b err=%b data=%h mv=%b want 1/1/0/0",
               ic_rsp_valid, rsp_err, ic_rsp_data, mem_req_valid);
    end
    ic_req_valid = 0;
    tick(); tick();
  endtask
`endif

  initial begin
    test_reset();
    test_ic_only();
    test_no_dup();
    test_back_to_back();
    test_writeback();
    test_rsp_ignored();
    test_reset_mid();
`ifdef LOWX_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lowx_arbiter.md
# lowx_arbiter

Two-requester arbiter that shares the single lower-level memory port between the instruction-cache miss path and the data-cache miss/writeback path. It sits between both caches and the memory/bus interface. It latches one granted request, sequences it through a request/response handshake with memory, and returns the response only to the granted requester. Arbitration is round-robin so neither cache starves.

## Interface
- `BLK_SIZE`, default 128: cache line width in bits; also the memory data width.
- `XLEN`, default 32: address width.
- `TIMEOUT_CYCLES`, default 1024: watchdog limit. Used only when `LOWX_ARB_TIMEOUT_EN` is defined.
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `ic_req_valid_i` in 1: I-cache fill request. Level signal, held until `ic_rsp_valid_o`.
- `ic_req_addr_i` in XLEN: I-cache line address.
- `ic_rsp_valid_o` out 1: one-cycle response pulse to the I-cache.
- `ic_rsp_data_o` out BLK_SIZE: fill data. Valid only with `ic_rsp_valid_o`.
- `dc_req_valid_i` in 1: D-cache request. Level signal, held until `dc_rsp_valid_o`.
- `dc_req_addr_i` in XLEN: D-cache line address.
- `dc_req_we_i` in 1: 1 = writeback, 0 = fill.
- `dc_req_wdata_i` in BLK_SIZE: writeback line.
- `dc_rsp_valid_o` out 1: one-cycle response pulse to the D-cache.
- `dc_rsp_data_o` out BLK_SIZE: fill data. All zeros for a writeback.
- `rsp_err_o` out 1: qualifies whichever `*_rsp_valid_o` is high; 1 = timed out.
- `mem_req_valid_o` out 1: memory request valid.
- `mem_req_ready_i` in 1: memory accepts the request.
- `mem_req_addr_o` out XLEN: memory request address.
- `mem_req_we_o` out 1: memory write enable.
- `mem_req_wdata_o` out BLK_SIZE: memory write data.
- `mem_rsp_valid_i` in 1: memory response valid.
- `mem_rsp_data_i` in BLK_SIZE: memory response data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Eligible requester: its valid is high and it is not masked.
  - If none is eligible, remain in IDLE.
  - If exactly one is eligible, grant it.
  - If both are eligible, grant the one that is not `last_grant`.
  - On grant, register the requester's addr, we and wdata (I-cache: we=0, wdata=0). Set `gnt`, update `last_grant`, go to ISSUE.
- **ISSUE**
  - `mem_req_valid_o`=1, driven from the registered request.
  - On `mem_req_ready_i`=1, go to WAIT.
  - Address, we and wdata stay stable while waiting for ready.
- **WAIT**
  - On `mem_rsp_valid_i`=1, register `mem_rsp_data_i` (zeros if we=1) and go to RESP.
- **RESP**
  - Assert the granted requester's `*_rsp_valid_o` for exactly one cycle, then go to IDLE.
  - Set the post-response mask bit for that requester. It clears after one IDLE cycle, which prevents re-granting a request the requester has not yet dropped.
- `mem_rsp_valid_i` outside WAIT is ignored.
- A requester dropping valid after it has been granted does not cancel the transaction.

## Timing
- Reset values: all outputs 0, state=IDLE, `last_grant`=D-cache (the I-cache wins the first tie), masks=0, data registers=0.
- Reset asserted mid-transaction aborts the transaction immediately; no response is issued.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- Minimum latency:
  - Request seen in IDLE at cycle N.
  - ISSUE at N+1; ready accepted at N+1.
  - WAIT at N+2; response accepted at N+2 or later.
  - `*_rsp_valid_o` at N+3.
- `mem_rsp_valid_i` in the same cycle as request acceptance is ignored.
- Back-to-back: with both requesters continuously valid, grants alternate IC, DC, IC, …

## Configuration
- `LOWX_ARB_TIMEOUT_EN` defined:
  - A `$clog2(TIMEOUT_CYCLES)+1`-bit counter clears on entry to ISSUE and increments each cycle in ISSUE and WAIT.
  - When the counter reaches TIMEOUT_CYCLES−1 without the state advancing, go to RESP with `rsp_err_o`=1 and data zero.
  - `mem_req_valid_o` drops on the timeout.
- `LOWX_ARB_TIMEOUT_EN` not defined: no counter; the arbiter waits indefinitely, and `rsp_err_o` is tied to 0.

## Structure
- Shared package `tcore_param` holds:
  - `lowx_arb_state_e`: IDLE, ISSUE, WAIT, RESP.
  - `lowx_gnt_e`: GNT_IC, GNT_DC.
  - A packed `lowx_arb_req_t` {addr, we, wdata}.
  - Default `LOWX_TIMEOUT` constant.
- Sub-module `rr_arb2`: combinational two-way round-robin pick from valid, mask and `last_grant`.
- The FSM and datapath registers live in `lowx_arbiter`.

## Test plan
- IC-only request, addr 0x0000_1040; ready in the first ISSUE cycle; memory responds 2 cycles later with 0xDEAD… → `ic_rsp_valid_o` pulses once with that data; `mem_req_we_o`=0; DC outputs stay 0.
- IC and DC raised together after reset → IC served first, then DC. `mem_req_addr_o` sequence is IC addr then DC addr; grants alternate over 4 transactions.
- DC writeback, we=1, wdata 0xA5… repeated; ready held low for 5 cycles → address and wdata stable through all stall cycles; `dc_rsp_data_o`=0 on response.
- Requester holds valid for 1 cycle after its response → no duplicate grant; `mem_req_valid_o` stays 0.
- `rst_i` asserted while in WAIT → next cycle state is IDLE with all outputs 0; a following `mem_rsp_valid_i` is ignored.
- Macro defined, TIMEOUT_CYCLES=16, memory never responds → response with `rsp_err_o`=1 and data 0, 16 cycles after entry to ISSUE.
